tank_motion_controller: RTL and testbench
=========================================

Name: tank_motion_controller

Overview:
- Per-frame movement sequencer for the tank sprite in the VGA draw path.
- On each end-of-frame tick it samples the direction buttons and computes a candidate position.
- It bounds-checks the candidate, then queries the tile map for the two leading corners through a req/ack lookup port.
- It commits or rejects the move. Its outputs drive the sprite position and orientation used by the pixel-draw block.

Parameters:
Pixels_Horiz, 640, active horizontal pixels
Pixels_Vert, 480, active vertical pixels
EdgeWidth, 20, border keep-out in pixels
xWidth, 60, tank width in pixels
yWidth, 60, tank height in pixels
Step, 1, pixels moved per accepted frame
Tile_Shift, 5, log2 of tile size (32 px)
Wall_Code, 4'h0, map tile code that blocks movement
Ack_Timeout, 15, max cycles to wait for Map_Ack
X_Init, 290, reset x position
Y_Init, 210, reset y position

Ports:
Master_Clock_In  in  1  system clock
Reset_N_In  in  1  reset; synchronous, active-low
Frame_Tick  in  1  one-cycle pulse at the end of the active frame
Up, Down, Left, Right  in  1 each  direction buttons, already synchronised
Map_Req  out  1  tile lookup request
Map_Col  out  5  tile column = x >> Tile_Shift
Map_Row  out  4  tile row = y >> Tile_Shift
Map_Ack  in  1  lookup acknowledge; Map_Tile is valid in the same cycle
Map_Tile  in  4  tile code
xPosition  out  10  committed tank x (left edge)
yPosition  out  10  committed tank y (top edge)
Direction  out  2  0 = up, 1 = down, 2 = left, 3 = right
Busy  out  1  high in any state other than IDLE
Move_Done  out  1  one-cycle pulse when a move is committed
Move_Blocked  out  1  one-cycle pulse when a move is rejected

Behaviour:
- Reset (Reset_N_In = 0 at a clock edge):
  - xPosition = X_Init, yPosition = Y_Init, Direction = 0.
  - Map_Req = 0, Move_Done = 0, Move_Blocked = 0.
  - State = IDLE, timeout counter = 0.
  - Reset wins over every other event, including mid-lookup; an outstanding request is abandoned.
- State machine: IDLE, CALC, CHK_A, CHK_B, COMMIT, REJECT.
- IDLE:
  - Frame_Tick = 1 samples the buttons, priority Up > Down > Left > Right.
  - No button pressed: stay in IDLE, no pulses.
  - Otherwise latch the direction, set Direction immediately (the tank turns even if the move is later blocked), go to CALC.
- Frame_Tick while Busy is ignored; it is not queued.
- CALC (1 cycle):
  - Candidate nx/ny = position ± Step on the selected axis, computed at 11 bits signed so underflow is detectable.
  - Out of bounds means nx < EdgeWidth, or nx + xWidth > Pixels_Horiz − EdgeWidth, or the same rules on the y axis. Out of bounds goes to REJECT; otherwise go to CHK_A.
- Corner pairs (A, B) per direction:
  - Up: (nx, ny), (nx+xWidth−1, ny)
  - Down: (nx, ny+yWidth−1), (nx+xWidth−1, ny+yWidth−1)
  - Left: (nx, ny), (nx, ny+yWidth−1)
  - Right: (nx+xWidth−1, ny), (nx+xWidth−1, ny+yWidth−1)
- CHK_A / CHK_B handshake:
  - Map_Req is registered high on state entry, with Map_Col/Map_Row stable while Req is high.
  - Map_Ack sampled high: Req drops on the next edge.
  - Map_Tile == Wall_Code goes to REJECT; otherwise CHK_A goes to CHK_B and CHK_B goes to COMMIT.
  - The timeout counter resets on state entry. If Ack_Timeout cycles pass without Ack, drop Req and go to REJECT.
  - Map_Ack while Req is low is ignored.
- COMMIT (1 cycle): xPosition/yPosition take nx/ny, pulse Move_Done, return to IDLE.
- REJECT (1 cycle): position unchanged, pulse Move_Blocked, return to IDLE.
- Latency, tick to Move_Done with zero-wait ack: 1 cycle (IDLE) + 1 (CALC) + 2 per check = 6 cycles. Each cycle of ack wait adds 1.
- Positions never leave the legal range, so no wrap-around is possible.

Test Plan:
- Reset, then Frame_Tick with no buttons -> x = 290, y = 210, Direction = 0, no pulses, Busy stays 0.
- Up held, one tick, map all code 3, ack 1 cycle after req -> Map_Col/Row = 9/6 then 10/6, Move_Done at cycle 6, y = 209, x = 290.
- Up + Left held together -> Up wins, Direction = 0, only y changes.
- y = 20, Up, tick -> Move_Blocked with no Map_Req issued, Direction = 0, y stays 20. Repeat for x = 560 with Right.
- Right with corner B tile = 0 -> both lookups issued, Move_Blocked, x unchanged, Direction = 3.
- Map_Ack never asserted -> Req held 15 cycles, then Move_Blocked. Extra tick while Busy is ignored. Reset asserted mid-CHK_A -> Req = 0 and state IDLE next cycle.

Source files
------------

// File: rtl/tank_motion_controller.sv
// Per-frame tank movement sequencer: samples buttons on Frame_Tick, bounds-checks the
// candidate position, looks up the two leading corner tiles, then commits or rejects.
module tank_motion_controller #(
    parameter int         Pixels_Horiz = 640,
    parameter int         Pixels_Vert  = 480,
    parameter int         EdgeWidth    = 20,
    parameter int         xWidth       = 60,
    parameter int         yWidth       = 60,
    parameter int         Step         = 1,
    parameter int         Tile_Shift   = 5,
    parameter logic [3:0] Wall_Code    = 4'h0,
    parameter int         Ack_Timeout  = 15,
    parameter int         X_Init       = 290,
    parameter int         Y_Init       = 210
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic       Frame_Tick,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    output logic       Map_Req,
    output logic [4:0] Map_Col,
    output logic [3:0] Map_Row,
    input  logic       Map_Ack,
    input  logic [3:0] Map_Tile,
    output logic [9:0] xPosition,
    output logic [9:0] yPosition,
    output logic [1:0] Direction,
    output logic       Busy,
    output logic       Move_Done,
    output logic       Move_Blocked
);

    localparam int CW = $clog2(Ack_Timeout + 1);

    localparam logic signed [10:0] L_XMIN = 11'(EdgeWidth);
    localparam logic signed [10:0] L_XMAX = 11'(Pixels_Horiz - EdgeWidth - xWidth);
    localparam logic signed [10:0] L_YMIN = 11'(EdgeWidth);
    localparam logic signed [10:0] L_YMAX = 11'(Pixels_Vert - EdgeWidth - yWidth);
    localparam logic signed [10:0] L_STEP = 11'(Step);
    localparam logic signed [10:0] L_XOFF = 11'(xWidth - 1);
    localparam logic signed [10:0] L_YOFF = 11'(yWidth - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_CHK_A, S_CHK_B, S_COMMIT, S_REJECT
    } state_t;

    state_t r_state, w_next;

    logic [9:0]    r_x, r_y;
    logic [1:0]    r_dir;
    logic          r_req, r_got, r_wall;
    logic [4:0]    r_col;
    logic [3:0]    r_row;
    logic [CW-1:0] r_cnt;
    logic          r_done, r_blk;

    logic               w_any, w_oob, w_timeout, w_enter_a, w_enter_b;
    logic [1:0]         w_sel_dir;
    logic signed [10:0] w_x0, w_y0, w_nx, w_ny;
    logic [10:0]        w_ax, w_ay, w_bx, w_by;
    logic               w_unused;

    assign w_any = Up | Down | Left | Right;
    assign w_sel_dir = Up ? DIR_UP : Down ? DIR_DOWN : Left ? DIR_LEFT : DIR_RIGHT;

    // Candidate is signed so a step below zero shows up as negative, not a wrap.
    assign w_x0 = $signed({1'b0, r_x});
    assign w_y0 = $signed({1'b0, r_y});

    always_comb begin
        w_nx = w_x0;
        w_ny = w_y0;
        case (r_dir)
            DIR_UP:   w_ny = w_y0 - L_STEP;
            DIR_DOWN: w_ny = w_y0 + L_STEP;
            DIR_LEFT: w_nx = w_x0 - L_STEP;
            default:  w_nx = w_x0 + L_STEP;
        endcase
    end

    assign w_oob = (w_nx < L_XMIN) || (w_nx > L_XMAX) || (w_ny < L_YMIN) || (w_ny > L_YMAX);

    // Leading corners: A/B share the edge facing the direction of travel.
    assign w_ax = w_nx + ((r_dir == DIR_RIGHT) ? L_XOFF : 11'sd0);
    assign w_ay = w_ny + ((r_dir == DIR_DOWN)  ? L_YOFF : 11'sd0);
    assign w_bx = w_nx + ((r_dir == DIR_LEFT)  ? 11'sd0 : L_XOFF);
    assign w_by = w_ny + ((r_dir == DIR_UP)    ? 11'sd0 : L_YOFF);

    assign w_unused = ^{w_ax, w_ay, w_bx, w_by, w_nx[10], w_ny[10]};

    assign w_timeout = r_req && !Map_Ack && (r_cnt == CW'(Ack_Timeout - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (Frame_Tick && w_any) w_next = S_CALC;
            S_CALC:   w_next = w_oob ? S_REJECT : S_CHK_A;
            S_CHK_A: begin
                if (w_timeout || (r_got && r_wall)) w_next = S_REJECT;
                else if (r_got)                     w_next = S_CHK_B;
            end
            S_CHK_B: begin
                if (w_timeout || (r_got && r_wall)) w_next = S_REJECT;
                else if (r_got)                     w_next = S_COMMIT;
            end
            S_COMMIT: w_next = S_IDLE;
            S_REJECT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_enter_a = (w_next == S_CHK_A) && (r_state != S_CHK_A);
    assign w_enter_b = (w_next == S_CHK_B) && (r_state != S_CHK_B);

    always_ff @(posedge Master_Clock_In) begin
        if (!Reset_N_In) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    always_ff @(posedge Master_Clock_In) begin
        if (!Reset_N_In) begin
            r_x    <= 10'(X_Init);
            r_y    <= 10'(Y_Init);
            r_dir  <= DIR_UP;
            r_req  <= 1'b0;
            r_got  <= 1'b0;
            r_wall <= 1'b0;
            r_col  <= '0;
            r_row  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_blk  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_blk  <= 1'b0;
            if (r_state == S_IDLE && Frame_Tick && w_any)
                r_dir <= w_sel_dir;
            if (w_enter_a || w_enter_b) begin
                r_req <= 1'b1;
                r_got <= 1'b0;
                r_cnt <= '0;
                r_col <= w_enter_a ? w_ax[Tile_Shift +: 5] : w_bx[Tile_Shift +: 5];
                r_row <= w_enter_a ? w_ay[Tile_Shift +: 4] : w_by[Tile_Shift +: 4];
            end else if (r_req) begin
                if (Map_Ack) begin
                    r_req  <= 1'b0;
                    r_got  <= 1'b1;
                    r_wall <= (Map_Tile == Wall_Code);
                end else if (w_timeout) begin
                    r_req <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            // Position and pulses update on entry so they are visible in the COMMIT/REJECT cycle.
            if (w_next == S_COMMIT && r_state != S_COMMIT) begin
                r_x    <= w_nx[9:0];
                r_y    <= w_ny[9:0];
                r_done <= 1'b1;
            end
            if (w_next == S_REJECT && r_state != S_REJECT)
                r_blk <= 1'b1;
        end
    end

    assign Map_Req      = r_req;
    assign Map_Col      = r_col;
    assign Map_Row      = r_row;
    assign xPosition    = r_x;
    assign yPosition    = r_y;
    assign Direction    = r_dir;
    assign Busy         = (r_state != S_IDLE);
    assign Move_Done    = r_done;
    assign Move_Blocked = r_blk;

endmodule

// File: tb/tb_tank_motion_controller.sv
// Directed bench for tank_motion_controller: table of single moves plus hand-written
// sequences for bounds, timeout, busy tick, idle ack and mid-lookup reset.
module tb_tank_motion_controller;

    logic       Master_Clock_In = 1'b0;
    logic       Reset_N_In = 1'b0;
    logic       Frame_Tick = 1'b0;
    logic       Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0;
    logic       Map_Req;
    logic [4:0] Map_Col;
    logic [3:0] Map_Row;
    logic       Map_Ack = 1'b0;
    logic [3:0] Map_Tile = 4'h0;
    logic [9:0] xPosition, yPosition;
    logic [1:0] Direction;
    logic       Busy, Move_Done, Move_Blocked;

    tank_motion_controller dut (
        .Master_Clock_In(Master_Clock_In), .Reset_N_In(Reset_N_In), .Frame_Tick(Frame_Tick),
        .Up(Up), .Down(Down), .Left(Left), .Right(Right),
        .Map_Req(Map_Req), .Map_Col(Map_Col), .Map_Row(Map_Row),
        .Map_Ack(Map_Ack), .Map_Tile(Map_Tile),
        .xPosition(xPosition), .yPosition(yPosition), .Direction(Direction),
        .Busy(Busy), .Move_Done(Move_Done), .Move_Blocked(Move_Blocked)
    );

    always #5 Master_Clock_In = ~Master_Clock_In;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One move: tick with buttons held, act as the tile map, stop at the first pulse.
    // pulse: 1 = Move_Done, 2 = Move_Blocked, 0 = none within the cycle budget.
    task automatic do_move(input logic [3:0] btn, input logic [3:0] ta, input logic [3:0] tb_,
                           input int delay, input int btick,
                           output int pulse, output int cyc, output int nreq, output int reqcyc,
                           output int ca, output int ra, output int cb, output int rb,
                           output int dir, output int x, output int y);
        int w;
        logic prev;
        pulse = 0; cyc = 0; nreq = 0; reqcyc = 0;
        ca = 0; ra = 0; cb = 0; rb = 0; dir = -1; x = -1; y = -1;
        w = 0; prev = 1'b0;
        @(negedge Master_Clock_In);
        {Up, Down, Left, Right} = btn;
        Frame_Tick = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Master_Clock_In);
            Frame_Tick = (c == btick);
            Map_Ack  = 1'b0;
            Map_Tile = 4'h0;
            if (Move_Done || Move_Blocked) begin
                pulse = Move_Done ? 1 : 2;
                cyc = c; dir = Direction; x = xPosition; y = yPosition;
                break;
            end
            if (Map_Req) begin
                reqcyc++;
                if (!prev) begin
                    nreq++;
                    w = 0;
                    if (nreq == 1) begin ca = Map_Col; ra = Map_Row; end
                    else           begin cb = Map_Col; rb = Map_Row; end
                end
                if (w == delay) begin
                    Map_Ack  = 1'b1;
                    Map_Tile = (nreq == 1) ? ta : tb_;
                end else begin
                    w++;
                end
            end
            prev = Map_Req;
        end
        Map_Ack = 1'b0;
        Frame_Tick = 1'b0;
        {Up, Down, Left, Right} = 4'b0000;
    endtask

    typedef struct {
        logic [3:0] btn;       // {Up, Down, Left, Right}
        logic [3:0] tile_a;
        logic [3:0] tile_b;
        int         delay;
        int         pulse;     // 1 done, 2 blocked
        int         cyc;
        int         nreq;
        int         dir;
        int         x, y;
        int         ca, ra, cb, rb;
    } vec_t;

    vec_t vecs[8];
    int pulse, cyc, nreq, reqcyc, ca, ra, cb, rb, dir, x, y;
    int quiet, dones, waitc;

    initial begin
        vecs[0] = '{4'b1000, 4'h3, 4'h3, 0, 1, 6, 2, 0, 290, 209,  9, 6, 10, 6};
        vecs[1] = '{4'b1010, 4'h3, 4'h3, 0, 1, 6, 2, 0, 290, 208,  9, 6, 10, 6};
        vecs[2] = '{4'b0100, 4'h3, 4'h3, 1, 1, 8, 2, 1, 290, 209,  9, 8, 10, 8};
        vecs[3] = '{4'b0010, 4'h2, 4'h2, 0, 1, 6, 2, 2, 289, 209,  9, 6,  9, 8};
        vecs[4] = '{4'b0001, 4'h3, 4'h0, 0, 2, 6, 2, 3, 289, 209, 10, 6, 10, 8};
        vecs[5] = '{4'b0010, 4'h0, 4'h3, 0, 2, 4, 1, 2, 289, 209,  9, 6,  0, 0};
        vecs[6] = '{4'b0001, 4'h5, 4'h7, 0, 1, 6, 2, 3, 290, 209, 10, 6, 10, 8};
        vecs[7] = '{4'b0101, 4'hF, 4'hF, 0, 1, 6, 2, 1, 290, 210,  9, 8, 10, 8};

        repeat (3) @(posedge Master_Clock_In);
        @(negedge Master_Clock_In);
        check("rst_x", xPosition, 290);
        check("rst_y", yPosition, 210);
        check("rst_dir", Direction, 0);
        check("rst_req", Map_Req, 0);
        check("rst_busy", Busy, 0);
        check("rst_pulses", {Move_Done, Move_Blocked}, 0);
        Reset_N_In = 1'b1;

        // Tick with no buttons: nothing happens.
        @(negedge Master_Clock_In);
        Frame_Tick = 1'b1;
        quiet = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Master_Clock_In);
            Frame_Tick = 1'b0;
            quiet += int'(Busy) + int'(Move_Done) + int'(Move_Blocked) + int'(Map_Req);
        end
        check("nobtn_activity", quiet, 0);
        check("nobtn_x", xPosition, 290);
        check("nobtn_y", yPosition, 210);

        for (int i = 0; i < 8; i++) begin
            do_move(vecs[i].btn, vecs[i].tile_a, vecs[i].tile_b, vecs[i].delay, 0,
                    pulse, cyc, nreq, reqcyc, ca, ra, cb, rb, dir, x, y);
            check($sformatf("v%0d_pulse", i), pulse, vecs[i].pulse);
            check($sformatf("v%0d_cyc", i), cyc, vecs[i].cyc);
            check($sformatf("v%0d_nreq", i), nreq, vecs[i].nreq);
            check($sformatf("v%0d_dir", i), dir, vecs[i].dir);
            check($sformatf("v%0d_x", i), x, vecs[i].x);
            check($sformatf("v%0d_y", i), y, vecs[i].y);
            if (vecs[i].nreq >= 1) begin
                check($sformatf("v%0d_colA", i), ca, vecs[i].ca);
                check($sformatf("v%0d_rowA", i), ra, vecs[i].ra);
            end
            if (vecs[i].nreq >= 2) begin
                check($sformatf("v%0d_colB", i), cb, vecs[i].cb);
                check($sformatf("v%0d_rowB", i), rb, vecs[i].rb);
            end
        end

        // Ack never comes; a second tick arrives mid-lookup and must be dropped.
        do_move(4'b1000, 4'h3, 4'h3, 99, 5, pulse, cyc, nreq, reqcyc, ca, ra, cb, rb, dir, x, y);
        check("tmo_pulse", pulse, 2);
        check("tmo_req_cycles", reqcyc, 15);
        check("tmo_cyc", cyc, 17);
        check("tmo_nreq", nreq, 1);
        check("tmo_y", y, 210);
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Master_Clock_In);
            quiet += int'(Busy) + int'(Move_Done) + int'(Move_Blocked) + int'(Map_Req);
        end
        check("busy_tick_ignored", quiet, 0);

        // Ack with no request outstanding has no effect.
        Map_Ack = 1'b1;
        Map_Tile = 4'h0;
        quiet = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Master_Clock_In);
            quiet += int'(Busy) + int'(Move_Done) + int'(Move_Blocked) + int'(Map_Req);
        end
        Map_Ack = 1'b0;
        check("idle_ack_ignored", quiet, 0);

        // Walk up to the top keep-out, then try one more step.
        dones = 0;
        for (int i = 0; i < 190; i++) begin
            do_move(4'b1000, 4'h1, 4'h1, 0, 0, pulse, cyc, nreq, reqcyc, ca, ra, cb, rb, dir, x, y);
            if (pulse == 1) dones++;
        end
        check("walk_up_dones", dones, 190);
        check("walk_up_y", yPosition, 20);
        do_move(4'b1000, 4'h1, 4'h1, 0, 0, pulse, cyc, nreq, reqcyc, ca, ra, cb, rb, dir, x, y);
        check("top_pulse", pulse, 2);
        check("top_cyc", cyc, 2);
        check("top_nreq", nreq, 0);
        check("top_dir", dir, 0);
        check("top_y", y, 20);

        // Walk right to the right keep-out, then try one more step.
        dones = 0;
        for (int i = 0; i < 270; i++) begin
            do_move(4'b0001, 4'h1, 4'h1, 0, 0, pulse, cyc, nreq, reqcyc, ca, ra, cb, rb, dir, x, y);
            if (pulse == 1) dones++;
        end
        check("walk_right_dones", dones, 270);
        check("walk_right_x", xPosition, 560);
        do_move(4'b0001, 4'h1, 4'h1, 0, 0, pulse, cyc, nreq, reqcyc, ca, ra, cb, rb, dir, x, y);
        check("right_pulse", pulse, 2);
        check("right_nreq", nreq, 0);
        check("right_dir", dir, 3);
        check("right_x", x, 560);

        // Reset in the middle of the first lookup abandons it.
        @(negedge Master_Clock_In);
        Down = 1'b1;
        Frame_Tick = 1'b1;
        @(negedge Master_Clock_In);
        Frame_Tick = 1'b0;
        waitc = 0;
        while (!Map_Req && waitc < 10) begin
            @(negedge Master_Clock_In);
            waitc++;
        end
        check("mid_req_seen", Map_Req, 1);
        check("mid_busy", Busy, 1);
        Reset_N_In = 1'b0;
        @(negedge Master_Clock_In);
        check("mid_rst_req", Map_Req, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_x", xPosition, 290);
        check("mid_rst_y", yPosition, 210);
        check("mid_rst_dir", Direction, 0);
        Reset_N_In = 1'b1;
        Down = 1'b0;

        do_move(4'b0100, 4'h2, 4'h2, 0, 0, pulse, cyc, nreq, reqcyc, ca, ra, cb, rb, dir, x, y);
        check("post_rst_pulse", pulse, 1);
        check("post_rst_cyc", cyc, 6);
        check("post_rst_y", y, 211);
        check("post_rst_rowA", ra, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
